// File: rtl/servo_pkg.sv
// Shared servo definitions: position codes, 12 MHz timing constants common to the
// PWM generator and decoder, and the decoder state encoding.
package servo_pkg;

  localparam logic [1:0] POS_LEFT   = 2'b00;
  localparam logic [1:0] POS_RIGHT  = 2'b01;
  localparam logic [1:0] POS_CENTRE = 2'b11;

  localparam int CLK_HZ = 12_000_000;
  localparam int MS_20  = 240_000;

  // Generator high-time counts; a `count <= X` pulse is X+1 cycles long.
  localparam int PULSE_LEFT   = 6_000;
  localparam int PULSE_CENTRE = 18_000;
  localparam int PULSE_RIGHT  = 30_000;

  localparam int MIN_WIDTH_CYC  = 3_000;
  localparam int MAX_WIDTH_CYC  = 36_000;
  localparam int LEFT_MAX_CYC   = 12_000;
  localparam int RIGHT_MIN_CYC  = 24_000;
  localparam int PERIOD_MIN_CYC = 200_000;
  localparam int PERIOD_MAX_CYC = 280_000;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_ARMED,
    ST_HIGH,
    ST_LOW
  } dec_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, followed by registered
// rise/fall strobes. Both edges reach the strobes with the same 3-cycle delay.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic ready,
  output logic rise,
  output logic fall
);

  logic       meta;
  logic       prev;
  logic [2:0] prime;

  // NOTE: non-blocking assignments make every flop sample the pre-edge value of
  // its neighbour, which is what turns these statements into a shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
      prime <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= sig;
      level <= meta;
      prev  <= level;
      prime <= {prime[1:0], 1'b1};
      // Edges are only trusted once the chain holds real samples, so reset
      // values never masquerade as a transition.
      rise  <= prime[2] & level & ~prev;
      fall  <= prime[2] & ~level & prev;
    end
  end

  assign ready = prime[1];

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures high time and rise-to-rise period of a servo pulse train, validates
// each frame and publishes the accepted width and decoded position.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int MIN_WIDTH  = MIN_WIDTH_CYC,
  parameter int MAX_WIDTH  = MAX_WIDTH_CYC,
  parameter int LEFT_MAX   = LEFT_MAX_CYC,
  parameter int RIGHT_MIN  = RIGHT_MIN_CYC,
  parameter int PERIOD_MIN = PERIOD_MIN_CYC,
  parameter int PERIOD_MAX = PERIOD_MAX_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             servo_in,
  output logic [CNT_W-1:0] width,
  output logic [1:0]       position,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             locked
);

  localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_W   = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] LEFT_M  = CNT_W'(LEFT_MAX);
  localparam logic [CNT_W-1:0] RIGHT_M = CNT_W'(RIGHT_MIN);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             level;
  logic             ready;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] width_meas;
  logic [1:0]       pos_meas;
  dec_state_e       state;
  dec_state_e       state_next;
  logic             latch_width;
  logic             evaluate;
  logic             timeout;
  logic             accept;
  logic             reject;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (servo_in),
    .level (level),
    .ready (ready),
    .rise  (rise),
    .fall  (fall)
  );

  // Both counters restart at 1 on every rise and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      pcnt <= '0;
    end else if (rise) begin
      wcnt <= CNT_ONE;
      pcnt <= CNT_ONE;
    end else begin
      if (wcnt != '1) wcnt <= wcnt + CNT_ONE;
      if (pcnt != '1) pcnt <= pcnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next  = state;
    latch_width = 1'b0;
    evaluate    = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      ST_SYNC:  if (ready && !level) state_next = ST_ARMED;
      ST_ARMED: if (rise) state_next = ST_HIGH;
      ST_HIGH: begin
        if (fall) begin
          latch_width = 1'b1;
          state_next  = ST_LOW;
        end else if (wcnt > MAX_W) begin
          timeout    = 1'b1;
          state_next = ST_SYNC;
        end
      end
      ST_LOW: begin
        if (rise) begin
          evaluate   = 1'b1;
          state_next = ST_HIGH;
        end else if (pcnt > P_MAX) begin
          timeout    = 1'b1;
          state_next = ST_ARMED;
        end
      end
      default: state_next = ST_SYNC;
    endcase
  end

  // pcnt still holds the finished period in the cycle the rise strobe is seen.
  assign accept = evaluate && (width_meas >= MIN_W) && (width_meas <= MAX_W)
                           && (pcnt >= P_MIN) && (pcnt <= P_MAX);
  assign reject = (evaluate && !accept) || timeout;

  always_comb begin
    pos_meas = POS_CENTRE;
    if (width_meas <= LEFT_M)       pos_meas = POS_LEFT;
    else if (width_meas >= RIGHT_M) pos_meas = POS_RIGHT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_meas  <= '0;
      width       <= '0;
      position    <= POS_CENTRE;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= accept;
      frame_err   <= reject;
      if (latch_width) width_meas <= wcnt;
      if (accept) begin
        width    <= width_meas;
        position <= pos_meas;
        locked   <= 1'b1;
      end else if (reject) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder; all timing parameters are scaled
// down by 100 so full frames stay short.
module tb_servo_pulse_decoder;

  localparam int CNT_W  = 20;
  localparam int MIN_W  = 30;
  localparam int MAX_W  = 360;
  localparam int LEFT_M = 120;
  localparam int RIGHT_M = 240;
  localparam int P_MIN  = 2000;
  localparam int P_MAX  = 2800;

  typedef enum int {EV_VALID, EV_ERR} ev_e;

  typedef struct {
    ev_e        kind;
    int         w;
    logic [1:0] p;
    logic       lock;
    longint     cyc;
  } exp_t;

  typedef struct {
    int         high;
    int         period;
    ev_e        kind;
    int         w;
    logic [1:0] p;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             servo_in = 1'b0;
  logic [CNT_W-1:0] width;
  logic [1:0]       position;
  logic             frame_valid;
  logic             frame_err;
  logic             locked;

  int         n_cmp = 0;
  int         n_fail = 0;
  longint     cycle = 0;
  exp_t       sb[$];
  exp_t       pend;
  bit         have_pend = 1'b0;
  int         last_w = 0;
  logic [1:0] last_p = 2'b11;
  longint     last_rise_c = 0;
  vec_t       tbl[15];

  servo_pulse_decoder #(
    .CNT_W      (CNT_W),
    .MIN_WIDTH  (MIN_W),
    .MAX_WIDTH  (MAX_W),
    .LEFT_MAX   (LEFT_M),
    .RIGHT_MIN  (RIGHT_M),
    .PERIOD_MIN (P_MIN),
    .PERIOD_MAX (P_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .servo_in    (servo_in),
    .width       (width),
    .position    (position),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic exp_t model(input int high, input int period);
    exp_t e;
    if (high >= MIN_W && high <= MAX_W && period >= P_MIN && period <= P_MAX) begin
      e.kind = EV_VALID;
      e.w    = high;
      e.p    = (high <= LEFT_M) ? 2'b00 : (high >= RIGHT_M) ? 2'b01 : 2'b11;
      e.lock = 1'b1;
    end else begin
      e.kind = EV_ERR;
      e.w    = last_w;
      e.p    = last_p;
      e.lock = 1'b0;
    end
    e.cyc = 0;
    return e;
  endfunction

  // A rise completes the pending frame: its verdict appears 4 cycles later.
  task automatic rise();
    if (have_pend) begin
      pend.cyc = cycle + 4;
      if (pend.kind == EV_VALID) begin
        last_w = pend.w;
        last_p = pend.p;
      end
      sb.push_back(pend);
      have_pend = 1'b0;
    end
    last_rise_c = cycle;
    servo_in = 1'b1;
  endtask

  task automatic frame(input int high, input int period);
    rise();
    repeat (high) @(negedge clk);
    servo_in = 1'b0;
    pend = model(high, period);
    have_pend = 1'b1;
    repeat (period - high) @(negedge clk);
  endtask

  task automatic timeout_low();
    exp_t e;
    have_pend = 1'b0;
    e.kind = EV_ERR;
    e.w    = last_w;
    e.p    = last_p;
    e.lock = 1'b0;
    e.cyc  = last_rise_c + P_MAX + 5;
    sb.push_back(e);
    repeat (int'(e.cyc - cycle) + 20) @(negedge clk);
  endtask

  task automatic stuck_high(input int hold);
    exp_t e;
    rise();
    e.kind = EV_ERR;
    e.w    = last_w;
    e.p    = last_p;
    e.lock = 1'b0;
    e.cyc  = last_rise_c + MAX_W + 5;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    servo_in = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (frame_valid || frame_err)) begin
      check("strobe_exclusive", frame_valid & frame_err, 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", frame_valid ? 1 : 2, 0);
      end else begin
        e = sb.pop_front();
        check("event_kind", frame_valid ? EV_VALID : EV_ERR, e.kind);
        check("event_cycle", cycle, e.cyc);
        check("event_width", width, e.w);
        check("event_position", position, e.p);
        check("event_locked", locked, e.lock);
      end
    end
  end

  initial begin
    tbl = '{
      '{61,  2401, EV_VALID, 61,  2'b00},
      '{61,  2401, EV_VALID, 61,  2'b00},
      '{61,  2401, EV_VALID, 61,  2'b00},
      '{181, 2401, EV_VALID, 181, 2'b11},
      '{301, 2401, EV_VALID, 301, 2'b01},
      '{120, 2401, EV_VALID, 120, 2'b00},
      '{121, 2401, EV_VALID, 121, 2'b11},
      '{240, 2401, EV_VALID, 240, 2'b01},
      '{181, 1500, EV_ERR,   240, 2'b01},
      '{30,  2000, EV_VALID, 30,  2'b00},
      '{360, 2800, EV_VALID, 360, 2'b01},
      '{29,  2401, EV_ERR,   360, 2'b01},
      '{181, 2801, EV_ERR,   360, 2'b01},
      '{181, 1999, EV_ERR,   360, 2'b01},
      '{181, 2401, EV_VALID, 181, 2'b11}
    };

    repeat (3) @(negedge clk);
    check("rst_width", width, 0);
    check("rst_position", position, 3);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_locked", locked, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    foreach (tbl[i]) begin
      frame(tbl[i].high, tbl[i].period);
      pend.kind = tbl[i].kind;
      pend.w    = tbl[i].w;
      pend.p    = tbl[i].p;
      pend.lock = (tbl[i].kind == EV_VALID);
    end

    // Input stalls low after a frame: one timeout, then re-lock after a frame.
    frame(61, 2401);
    timeout_low();
    frame(61, 2401);
    frame(181, 2401);

    // Input stuck high: one timeout, silence until a full frame follows.
    stuck_high(400);
    repeat (100) @(negedge clk);
    frame(301, 2401);

    // Asynchronous reset in the middle of a high pulse.
    rise();
    repeat (30) @(negedge clk);
    check("locked_before_rst", locked, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_width", width, 0);
    check("async_rst_position", position, 3);
    check("async_rst_frame_valid", frame_valid, 0);
    check("async_rst_frame_err", frame_err, 0);
    check("async_rst_locked", locked, 0);
    have_pend = 1'b0;
    last_w = 0;
    last_p = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    servo_in = 1'b0;
    repeat (50) @(negedge clk);

    frame(181, 2401);
    frame(301, 2401);
    rise();
    repeat (61) @(negedge clk);
    servo_in = 1'b0;
    repeat (20) @(negedge clk);
    check("locked_at_end", locked, 1);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
